hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32 core (IF/ID/EX/MEM/WB).
- Central point that sequences stalls, bubbles, flushes and data-memory freezes.
- Owns the 1-cycle wait for branch/JALR operands resolved in decode, and issues the registered forward selects for that path.
- Exports saturating stall and flush performance counters.

Parameters:
- RA_W, 5, register address width.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- id_rs1  in  RA_W  decode source register 1
- id_rs2  in  RA_W  decode source register 2
- id_rs1_used  in  1  decode instruction reads rs1
- id_rs2_used  in  1  decode instruction reads rs2
- id_br  in  1  decode holds a conditional branch or JALR; operands are needed in ID
- id_redirect  in  1  decode resolved a taken branch, JAL or JALR
- ex_rd  in  RA_W  EX destination register
- ex_wen  in  1  EX writes the register file
- ex_load  in  1  EX holds a load
- mem_rd  in  RA_W  MEM destination register
- mem_wen  in  1  MEM writes the register file
- dmem_busy  in  1  data memory not ready; freeze the pipeline
- cnt_clr  in  1  synchronous clear of both counters
- pc_we  out  1  PC update enable
- ifid_we  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID register loads NOP
- idex_bubble  out  1  ID/EX register loads NOP
- exmem_we  out  1  EX/MEM register enable
- memwb_we  out  1  MEM/WB register enable
- br_fwd_a  out  2  branch operand A source: 00 register file, 01 WB data, 10 MEM data
- br_fwd_b  out  2  same encoding, operand B
- br_fwd_valid  out  1  br_fwd_a/b are valid this cycle
- stall_cnt  out  CNT_W  cycles with pc_we = 0
- flush_cnt  out  CNT_W  cycles with ifid_flush = 1

Behaviour:
- Reset (async): state RUN; br_fwd_a = br_fwd_b = 00; br_fwd_valid = 0; counters = 0.
- Default outputs: all enables 1, ifid_flush/idex_bubble 0. These hold out of reset, since the enables are combinational from state and inputs.
- State machine: RUN and BR_WAIT. Control outputs are Mealy (combinational from state + inputs); state and br_fwd registers update on the clock.
- Match definitions: ex_hit_x = ex_wen & ex_rd != 0 & ex_rd == id_rsx & id_rsx_used; mem_hit_x is the same using mem_*. Register x0 never matches.
- Freeze: dmem_busy = 1 forces pc_we = ifid_we = exmem_we = memwb_we = 0 and ifid_flush = idex_bubble = 0. State, br_fwd_* and br_fwd_valid hold; no hazard or redirect action is taken. Freeze has highest priority in every state.
- RUN, not frozen, id_br = 0, load-use (ex_load & (ex_hit_1 | ex_hit_2)):
  - pc_we = ifid_we = 0, idex_bubble = 1 for exactly one cycle; stay RUN.
  - The next-cycle conflict is resolved by EX-stage forwarding.
- RUN, not frozen, id_br = 1, any ex_hit or mem_hit on a used source:
  - pc_we = ifid_we = 0, idex_bubble = 1; go to BR_WAIT.
  - Register per operand: 10 if ex_hit, else 01 if mem_hit, else 00. EX has priority over MEM (youngest producer wins).
  - EX producer: its data sits in MEM next cycle, where load data is taken from the MEM-stage memory output.
  - MEM producer: its data sits in WB next cycle.
- BR_WAIT, not frozen:
  - br_fwd_valid = 1; no stall; hazard detection suppressed.
  - Unconditionally return to RUN; clear br_fwd_* to 00 and br_fwd_valid to 0 on exit.
- Redirect: ifid_flush = 1 when id_redirect = 1, not frozen, and no stall is asserted this cycle. In RUN, id_redirect is ignored while the cycle stalls.
- Stall and redirect with id_br = 0 in RUN: stall wins; redirect is not flushed that cycle.
- Counters:
  - stall_cnt increments on each cycle with pc_we = 0, including freeze cycles.
  - flush_cnt increments on each cycle with ifid_flush = 1.
  - Both saturate at all-ones. cnt_clr zeroes both and has priority over increment.
- Reset asserted mid-BR_WAIT or mid-freeze returns to RUN immediately, without waiting for a clock edge.

Test Plan:
- Load x5 in EX; decode add uses rs1 = x5 -> one cycle with pc_we = 0, idex_bubble = 1; next cycle pc_we = 1; stall_cnt = 1.
- ALU write x7 in EX; decode beq rs2 = x7 -> stall cycle, then BR_WAIT with br_fwd_b = 10, br_fwd_a = 00, br_fwd_valid = 1; then RUN with br_fwd_b = 00.
- x3 written in both EX and MEM; decode JALR rs1 = x3 -> br_fwd_a = 10 (EX priority). Repeat with a MEM-only producer -> br_fwd_a = 01.
- ex_rd = 0, ex_wen = 1, id_rs1 = 0 with a branch -> no stall; id_redirect = 1 -> ifid_flush = 1 for one cycle; flush_cnt = 1.
- dmem_busy high for 3 cycles entered in BR_WAIT -> all enables 0; state and br_fwd_valid hold; resume BR_WAIT one cycle after busy drops; stall_cnt += 3.
- Preload counters near all-ones by forcing stalls -> stall_cnt saturates at all-ones; cnt_clr together with a stall cycle -> stall_cnt = 0. Assert rstn low in BR_WAIT -> outputs at reset values before the next edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline.
// Sequences stalls, bubbles, flushes, memory freezes and branch forwarding.
module hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_br,
  input  logic             id_redirect,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_wen,
  input  logic             ex_load,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_wen,
  input  logic             dmem_busy,
  input  logic             cnt_clr,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic [1:0]       br_fwd_a,
  output logic [1:0]       br_fwd_b,
  output logic             br_fwd_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] SRC_RF  = 2'b00;
  localparam logic [1:0] SRC_WB  = 2'b01;
  localparam logic [1:0] SRC_MEM = 2'b10;

  state_e     state_q, state_d;
  logic [1:0] fa_q, fa_d;
  logic [1:0] fb_q, fb_d;
  logic       fv_q, fv_d;

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic ex_hit1, ex_hit2;
  logic mem_hit1, mem_hit2;
  logic load_use, br_haz, hz;
  logic do_freeze, do_stall, do_flush;

  assign ex_hit1  = ex_wen & (ex_rd != '0)
                  & (ex_rd == id_rs1) & id_rs1_used;
  assign ex_hit2  = ex_wen & (ex_rd != '0)
                  & (ex_rd == id_rs2) & id_rs2_used;
  assign mem_hit1 = mem_wen & (mem_rd != '0)
                  & (mem_rd == id_rs1) & id_rs1_used;
  assign mem_hit2 = mem_wen & (mem_rd != '0)
                  & (mem_rd == id_rs2) & id_rs2_used;

  assign load_use = ex_load & (ex_hit1 | ex_hit2);
  assign br_haz   = ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2;
  assign hz       = id_br ? br_haz : load_use;

  // Mutually exclusive actions; freeze dominates, then stall, then flush
  assign do_freeze = dmem_busy;
  assign do_stall  = ~dmem_busy & (state_q == RUN) & hz;
  assign do_flush  = ~dmem_busy & ~do_stall & id_redirect;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      fa_q    <= SRC_RF;
      fb_q    <= SRC_RF;
      fv_q    <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fv_q    <= fv_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fv_d    = fv_q;
    if (!dmem_busy) begin
      unique case (state_q)
        RUN: begin
          if (id_br && br_haz) begin
            state_d = BR_WAIT;
            fa_d    = ex_hit1  ? SRC_MEM :
                      mem_hit1 ? SRC_WB  : SRC_RF;
            fb_d    = ex_hit2  ? SRC_MEM :
                      mem_hit2 ? SRC_WB  : SRC_RF;
            fv_d    = 1'b1;
          end
        end
        BR_WAIT: begin
          state_d = RUN;
          fa_d    = SRC_RF;
          fb_d    = SRC_RF;
          fv_d    = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    unique case (1'b1)
      do_freeze: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        exmem_we = 1'b0;
        memwb_we = 1'b0;
      end
      do_stall: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end
      do_flush: ifid_flush = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_clr) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!pc_we && stall_q != '1)
        stall_d = stall_q + CNT_W'(1);
      if (ifid_flush && flush_q != '1)
        flush_d = flush_q + CNT_W'(1);
    end
  end

  assign br_fwd_a     = fa_q;
  assign br_fwd_b     = fb_q;
  assign br_fwd_valid = fv_q;
  assign stall_cnt    = stall_q;
  assign flush_cnt    = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: per-cycle expected outputs
// are queued at drive time and compared just after inputs settle.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       id_rs1_used, id_rs2_used, id_br, id_redirect;
  logic       ex_wen, ex_load, mem_wen, dmem_busy, cnt_clr;
  logic       pc_we, ifid_we, ifid_flush, idex_bubble;
  logic       exmem_we, memwb_we, br_fwd_valid;
  logic [1:0] br_fwd_a, br_fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.RA_W(5), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_br(id_br), .id_redirect(id_redirect),
    .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_wen(mem_wen),
    .dmem_busy(dmem_busy), .cnt_clr(cnt_clr),
    .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_we(exmem_we), .memwb_we(memwb_we),
    .br_fwd_a(br_fwd_a), .br_fwd_b(br_fwd_b),
    .br_fwd_valid(br_fwd_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1, u2, br, rdr;
    logic [4:0] exrd;
    logic       exw, exl;
    logic [4:0] mrd;
    logic       mw, busy, clr;
  } in_t;

  // {pc,ifid,flush,bubble,exmem,memwb, fa, fb, fv}
  typedef logic [10:0] ctl_t;
  typedef logic [42:0] obs_t;

  localparam logic [5:0] N = 6'b110011;
  localparam logic [5:0] S = 6'b000111;
  localparam logic [5:0] F = 6'b111011;
  localparam logic [5:0] Z = 6'b000000;

  int   nrun  = 0;
  int   nfail = 0;
  logic [15:0] es = '0;
  logic [15:0] ef = '0;
  obs_t sb[$];
  obs_t got;

  function automatic in_t si(
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic u1, input logic u2,
    input logic br, input logic rdr,
    input logic [4:0] exrd, input logic exw,
    input logic exl, input logic [4:0] mrd,
    input logic mw, input logic busy,
    input logic clr);
    in_t s;
    s = '{rs1, rs2, u1, u2, br, rdr, exrd,
          exw, exl, mrd, mw, busy, clr};
    return s;
  endfunction

  function automatic ctl_t c(input logic [5:0] en,
    input logic [1:0] fa, input logic [1:0] fb,
    input logic fv);
    return {en, fa, fb, fv};
  endfunction

  function automatic obs_t observe();
    return {pc_we, ifid_we, ifid_flush, idex_bubble,
            exmem_we, memwb_we, br_fwd_a, br_fwd_b,
            br_fwd_valid, stall_cnt, flush_cnt};
  endfunction

  function automatic obs_t mk(input ctl_t x);
    return {x, es, ef};
  endfunction

  task automatic drive(input in_t s);
    id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_rs1_used = s.u1; id_rs2_used = s.u2;
    id_br = s.br; id_redirect = s.rdr;
    ex_rd = s.exrd; ex_wen = s.exw; ex_load = s.exl;
    mem_rd = s.mrd; mem_wen = s.mw;
    dmem_busy = s.busy; cnt_clr = s.clr;
  endtask

  task automatic upd(input logic clr, input ctl_t x);
    if (clr) begin
      es = '0;
      ef = '0;
    end else begin
      if (!x[10] && es != 16'hffff) es = es + 16'd1;
      if (x[8] && ef != 16'hffff) ef = ef + 16'd1;
    end
  endtask

  in_t idle;

  task automatic test_reset();
    rstn = 1'b0;
    drive(idle);
    sb.push_back(mk(c(N, 2'b00, 2'b00, 1'b0)));
    #2;
    got = sb.pop_front();
    nrun++;
    if (observe() !== got) begin
      nfail++;
      $display("FAIL reset got %h exp %h", observe(), got);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_load_use();
    in_t st[$];
    ctl_t ec[$];
    st.push_back(si(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0));
    ec.push_back(c(S, 2'b00, 2'b00, 1'b0));
    st.push_back(si(5, 0, 1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0));
    ec.push_back(c(N, 2'b00, 2'b00, 1'b0));
    st.push_back(si(0, 9, 0, 1, 0, 1, 9, 1, 1, 0, 0, 0, 0));
    ec.push_back(c(S, 2'b00, 2'b00, 1'b0));
    st.push_back(idle);
    ec.push_back(c(N, 2'b00, 2'b00, 1'b0));
    foreach (st[i]) begin
      drive(st[i]);
      sb.push_back(mk(ec[i]));
      #2;
      got = sb.pop_front();
      nrun++;
      if (observe() !== got) begin
        nfail++;
        $display("FAIL load_use[%0d] got %h exp %h",
                 i, observe(), got);
      end
      upd(st[i].clr, ec[i]);
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    in_t st[$];
    ctl_t ec[$];
    // beq rs2=x7 behind ALU write x7
    st.push_back(si(1, 7, 1, 1, 1, 0, 7, 1, 0, 0, 0, 0, 0));
    ec.push_back(c(S, 2'b00, 2'b00, 1'b0));
    st.push_back(si(1, 7, 1, 1, 1, 0, 7, 1, 0, 0, 0, 0, 0));
    ec.push_back(c(N, 2'b00, 2'b10, 1'b1));
    st.push_back(idle);
    ec.push_back(c(N, 2'b00, 2'b00, 1'b0));
    // JALR rs1=x3, producers in EX and MEM
    st.push_back(si(3, 0, 1, 0, 1, 0, 3, 1, 0, 3, 1, 0, 0));
    ec.push_back(c(S, 2'b00, 2'b00, 1'b0));
    st.push_back(si(3, 0, 1, 0, 1, 1, 0, 0, 0, 3, 1, 0, 0));
    ec.push_back(c(F, 2'b10, 2'b00, 1'b1));
    st.push_back(idle);
    ec.push_back(c(N, 2'b00, 2'b00, 1'b0));
    // MEM-only producer
    st.push_back(si(3, 0, 1, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0));
    ec.push_back(c(S, 2'b00, 2'b00, 1'b0));
    st.push_back(idle);
    ec.push_back(c(N, 2'b01, 2'b00, 1'b1));
    st.push_back(idle);
    ec.push_back(c(N, 2'b00, 2'b00, 1'b0));
    foreach (st[i]) begin
      drive(st[i]);
      sb.push_back(mk(ec[i]));
      #2;
      got = sb.pop_front();
      nrun++;
      if (observe() !== got) begin
        nfail++;
        $display("FAIL branch[%0d] got %h exp %h",
                 i, observe(), got);
      end
      upd(st[i].clr, ec[i]);
      @(negedge clk);
    end
  endtask

  task automatic test_x0_redirect();
    in_t st[$];
    ctl_t ec[$];
    st.push_back(si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    ec.push_back(c(N, 2'b00, 2'b00, 1'b0));
    st.push_back(si(0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    ec.push_back(c(N, 2'b00, 2'b00, 1'b0));
    st.push_back(si(4, 0, 0, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0));
    ec.push_back(c(N, 2'b00, 2'b00, 1'b0));
    st.push_back(si(0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
    ec.push_back(c(F, 2'b00, 2'b00, 1'b0));
    st.push_back(idle);
    ec.push_back(c(N, 2'b00, 2'b00, 1'b0));
    foreach (st[i]) begin
      drive(st[i]);
      sb.push_back(mk(ec[i]));
      #2;
      got = sb.pop_front();
      nrun++;
      if (observe() !== got) begin
        nfail++;
        $display("FAIL x0_redirect[%0d] got %h exp %h",
                 i, observe(), got);
      end
      upd(st[i].clr, ec[i]);
      @(negedge clk);
    end
  endtask

  task automatic test_freeze();
    in_t st[$];
    ctl_t ec[$];
    st.push_back(si(7, 0, 1, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0));
    ec.push_back(c(S, 2'b00, 2'b00, 1'b0));
    for (int k = 0; k < 3; k++) begin
      st.push_back(si(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
      ec.push_back(c(Z, 2'b10, 2'b00, 1'b1));
    end
    st.push_back(idle);
    ec.push_back(c(N, 2'b10, 2'b00, 1'b1));
    st.push_back(idle);
    ec.push_back(c(N, 2'b00, 2'b00, 1'b0));
    // freeze over a load-use in RUN: no bubble
    st.push_back(si(5, 0, 1, 0, 0, 1, 5, 1, 1, 0, 0, 1, 0));
    ec.push_back(c(Z, 2'b00, 2'b00, 1'b0));
    st.push_back(idle);
    ec.push_back(c(N, 2'b00, 2'b00, 1'b0));
    foreach (st[i]) begin
      drive(st[i]);
      sb.push_back(mk(ec[i]));
      #2;
      got = sb.pop_front();
      nrun++;
      if (observe() !== got) begin
        nfail++;
        $display("FAIL freeze[%0d] got %h exp %h",
                 i, observe(), got);
      end
      upd(st[i].clr, ec[i]);
      @(negedge clk);
    end
  endtask

  task automatic test_saturate();
    in_t st[$];
    ctl_t ec[$];
    drive(si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    es = '0;
    ef = '0;
    drive(si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    repeat (65540) @(negedge clk);
    es = 16'hffff;
    st.push_back(si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    ec.push_back(c(Z, 2'b00, 2'b00, 1'b0));
    st.push_back(si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    ec.push_back(c(Z, 2'b00, 2'b00, 1'b0));
    st.push_back(idle);
    ec.push_back(c(N, 2'b00, 2'b00, 1'b0));
    foreach (st[i]) begin
      drive(st[i]);
      sb.push_back(mk(ec[i]));
      #2;
      got = sb.pop_front();
      nrun++;
      if (observe() !== got) begin
        nfail++;
        $display("FAIL saturate[%0d] got %h exp %h",
                 i, observe(), got);
      end
      upd(st[i].clr, ec[i]);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_brwait();
    drive(si(2, 0, 1, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(idle);
    #2;
    nrun++;
    if (br_fwd_valid !== 1'b1) begin
      nfail++;
      $display("FAIL brwait_entry got %b exp 1", br_fwd_valid);
    end
    rstn = 1'b0;
    sb.push_back({c(N, 2'b00, 2'b00, 1'b0), 16'h0, 16'h0});
    #1;
    got = sb.pop_front();
    nrun++;
    if (observe() !== got) begin
      nfail++;
      $display("FAIL async_reset got %h exp %h", observe(), got);
    end
    @(negedge clk);
    rstn = 1'b1;
    es = '0;
    ef = '0;
    @(negedge clk);
  endtask

  initial begin
    idle = '0;
    test_reset();
    test_load_use();
    test_branch();
    test_x0_redirect();
    test_freeze();
    test_saturate();
    test_reset_brwait();
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
